// File: rtl/ifetch_prefetch_pkg.sv
// Shared constants for the instruction fetch front end.
package ifetch_prefetch_pkg;

  localparam int          INST_W   = 32;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;  // addi x0, x0, 0
  localparam int          PC_STEP  = 4;

endpackage

// File: rtl/ifetch_prefetch_if.sv
// Instruction memory request/response channel: req/gnt transfer, in-order rvalid.
interface ifetch_prefetch_if #(
  parameter int ADDR_W = 32
);
  import ifetch_prefetch_pkg::*;

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              gnt;
  logic              rvalid;
  logic [INST_W-1:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/ifetch_prefetch_fetch_buf.sv
// Circular prefetch buffer. Entries are reserved at request time (tail),
// filled in order as responses arrive (fill), and popped to decode (head).
module fetch_buf
  import ifetch_prefetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   reserve,
  input  logic [ADDR_W-1:0]      reserve_addr,
  input  logic                   fill,
  input  logic [INST_W-1:0]      fill_data,
  input  logic                   pop,
  output logic                   head_filled,
  output logic [ADDR_W-1:0]      head_addr,
  output logic [INST_W-1:0]      head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic [$clog2(DEPTH):0] unfilled
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0]     head_ptr, fill_ptr, tail_ptr;
  logic [DEPTH-1:0]  filled;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [INST_W-1:0] data_mem [DEPTH];

  assign count       = tail_ptr - head_ptr;
  assign unfilled    = tail_ptr - fill_ptr;
  assign head_filled = filled[head_ptr[IW-1:0]];
  assign head_addr   = addr_mem[head_ptr[IW-1:0]];
  assign head_data   = data_mem[head_ptr[IW-1:0]];

  // Pointer and filled-flag bookkeeping; clear wipes every entry at once.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_ptr <= '0;
      fill_ptr <= '0;
      tail_ptr <= '0;
      filled   <= '0;
    end else if (clear) begin
      head_ptr <= '0;
      fill_ptr <= '0;
      tail_ptr <= '0;
      filled   <= '0;
    end else begin
      if (reserve) tail_ptr <= tail_ptr + PW'(1);
      if (fill) begin
        filled[fill_ptr[IW-1:0]] <= 1'b1;
        fill_ptr                 <= fill_ptr + PW'(1);
      end
      if (pop) begin
        filled[head_ptr[IW-1:0]] <= 1'b0;
        head_ptr                 <= head_ptr + PW'(1);
      end
    end
  end

  // Entry payload storage written on reserve (address) and fill (instruction).
  // NOTE: payload arrays are not reset; the filled flags alone decide whether they are observed.
  always_ff @(posedge clk) begin
    if (reserve) addr_mem[tail_ptr[IW-1:0]] <= reserve_addr;
    if (fill)    data_mem[fill_ptr[IW-1:0]] <= fill_data;
  end

endmodule

// File: rtl/ifetch_prefetch.sv
// Fetch front end: PC generation, pipelined instruction memory requests,
// stale-response dropping after redirects, and the decode-facing output mux.
module ifetch_prefetch
  import ifetch_prefetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               jump_en_i,
  input  logic [ADDR_W-1:0]  jump_addr_i,
  input  logic               hold_flag_i,
  ifetch_prefetch_if.master  rom,
  output logic               inst_valid_o,
  output logic [INST_W-1:0]  inst_o,
  output logic [ADDR_W-1:0]  inst_addr_o
);

  localparam int             CW      = $clog2(DEPTH) + 1;
  localparam int             DW      = $clog2(2 * DEPTH) + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

  logic [ADDR_W-1:0] pc;
  logic              req_en;
  logic [DW-1:0]     drop_cnt;
  logic [CW-1:0]     count, unfilled;
  logic              head_filled;
  logic [ADDR_W-1:0] head_addr;
  logic [INST_W-1:0] head_data;
  logic              grant, fill, pop, dropping, retire;

  // Request decode depends only on registered state plus the redirect input.
  assign rom.req  = req_en & (count < DEPTH_C) & ~jump_en_i;
  assign rom.addr = pc;

  assign grant    = rom.req & rom.gnt;
  assign dropping = drop_cnt != '0;
  assign fill     = rom.rvalid & ~dropping & (unfilled != '0) & ~jump_en_i;
  assign pop      = head_filled & ~hold_flag_i & ~jump_en_i;
  // A response arriving in a jump cycle retires one in-flight request either way.
  assign retire   = rom.rvalid & (dropping | (unfilled != '0));

  fetch_buf #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_buf (
    .clk          (clk),
    .rst          (rst),
    .clear        (jump_en_i),
    .reserve      (grant),
    .reserve_addr (pc),
    .fill         (fill),
    .fill_data    (rom.rdata),
    .pop          (pop),
    .head_filled  (head_filled),
    .head_addr    (head_addr),
    .head_data    (head_data),
    .count        (count),
    .unfilled     (unfilled)
  );

  // PC advance/redirect and the count of responses still owed to a flushed stream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= RESET_PC;
      req_en   <= 1'b0;
      drop_cnt <= '0;
    end else begin
      req_en <= 1'b1;
      if (jump_en_i) begin
        pc       <= jump_addr_i;
        drop_cnt <= drop_cnt + DW'(unfilled) - DW'(retire);
      end else begin
        if (grant)                   pc       <= pc + ADDR_W'(PC_STEP);
        if (rom.rvalid && dropping)  drop_cnt <= drop_cnt - DW'(1);
      end
    end
  end

  assign inst_valid_o = head_filled;
  assign inst_o       = head_filled ? head_data : INST_NOP;
  assign inst_addr_o  = head_filled ? head_addr : '0;

endmodule
